// File: rtl/sfx_sequencer.sv
// sfx_sequencer: arbitrates hit/score/flap requests and plays each effect as square-wave tone segments
module sfx_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic       Clk,
  input  logic       sys_reset,
  input  logic       en,
  input  logic       req_hit,
  input  logic       req_score,
  input  logic       req_flap,
  output logic       Speaker,
  output logic       busy,
  output logic [1:0] playing
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  state_t          r_state;
  logic [2:0]      r_pend;
  logic [1:0]      r_seg;
  logic [15:0]     r_hp;
  logic [7:0]      r_dur;
  logic [PW-1:0]   r_pre;
  logic            r_spk;
  logic            r_busy;
  logic [1:0]      r_play;

  logic [2:0]      w_req;
  logic [2:0]      w_all;
  logic [1:0]      w_req_top;
  logic [1:0]      w_all_top;
  logic [1:0]      w_sel;
  logic [1:0]      w_nseg;
  logic            w_preempt;
  logic            w_tick;
  logic            w_seg_end;
  logic            w_eff_end;
  logic            w_go;
  logic [2:0]      w_pend_nx;

  // Effect codes double as priorities: 1 flap, 2 score, 3 hit
  function automatic logic [1:0] top_of(input logic [2:0] v);
    return v[2] ? 2'd3 : v[1] ? 2'd2 : v[0] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] bit_of(input logic [1:0] e);
    return e == 2'd3 ? 3'b100 : e == 2'd2 ? 3'b010 : e == 2'd1 ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [15:0] hp_of(input logic [1:0] e, input logic [1:0] s);
    return e == 2'd1 ? (s == 2'd0 ? 16'd400 : 16'd300) :
           e == 2'd2 ? (s == 2'd0 ? 16'd250 : 16'd200) :
           (s == 2'd0 ? 16'd1200 : s == 2'd1 ? 16'd1600 : 16'd2000);
  endfunction

  function automatic logic [7:0] dur_of(input logic [1:0] e, input logic [1:0] s);
    return e == 2'd1 ? 8'd20 :
           e == 2'd2 ? (s == 2'd0 ? 8'd60 : 8'd120) :
           (s == 2'd2 ? 8'd200 : 8'd100);
  endfunction

  always_comb begin
    w_req     = {req_hit, req_score, req_flap} & {3{en}};
    w_all     = r_pend | w_req;
    w_req_top = top_of(w_req);
    w_all_top = top_of(w_all);
    w_nseg    = r_seg + 2'd1;
    w_preempt = (r_state != S_IDLE) && (w_req_top != 2'd0) && (w_req_top >= r_play);
    w_tick    = r_pre == '0;
    w_seg_end = (r_state == S_PLAY) && w_tick && (r_dur == 8'd1);
    w_eff_end = w_seg_end && (r_seg == (r_play == 2'd3 ? 2'd2 : 2'd1));
    w_sel     = w_preempt ? w_req_top : w_all_top;
    w_go      = (r_state == S_IDLE) ? |w_all : (w_preempt || (w_eff_end && |w_all));
    w_pend_nx = w_all & ~(w_go ? bit_of(w_sel) : 3'b000);
  end

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_seg   <= '0;
      r_hp    <= '0;
      r_dur   <= '0;
      r_pre   <= '0;
      r_spk   <= 1'b0;
      r_busy  <= 1'b0;
      r_play  <= '0;
    end else if (!en) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_spk   <= 1'b0;
      r_busy  <= 1'b0;
      r_play  <= '0;
    end else begin
      r_pend <= w_pend_nx;
      if (w_go) begin
        r_state <= S_LOAD;
        r_play  <= w_sel;
        r_busy  <= 1'b1;
        r_spk   <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_state <= S_PLAY;
        r_seg   <= '0;
        r_hp    <= hp_of(r_play, 2'd0) - 16'd1;
        r_dur   <= dur_of(r_play, 2'd0);
        r_pre   <= PRE_MAX;
      end else if (r_state == S_PLAY) begin
        r_pre <= w_tick ? PRE_MAX : r_pre - 1'b1;
        if (w_eff_end) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_play  <= '0;
          r_spk   <= 1'b0;
        end else if (w_seg_end) begin
          // Seamless segment change: speaker level is held across the boundary
          r_seg <= w_nseg;
          r_dur <= dur_of(r_play, w_nseg);
          r_hp  <= hp_of(r_play, w_nseg) - 16'd1;
        end else begin
          r_dur <= w_tick ? r_dur - 8'd1 : r_dur;
          r_hp  <= r_hp == 16'd0 ? hp_of(r_play, r_seg) - 16'd1 : r_hp - 16'd1;
          r_spk <= r_hp == 16'd0 ? ~r_spk : r_spk;
        end
      end
    end
  end

  assign Speaker = r_spk;
  assign busy    = r_busy;
  assign playing = r_play;
endmodule
